// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus between one initiator and one responder.
interface ahb_lite_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [1:0]            HTRANS;
    logic [3:0]            HPROT;
    logic                  HMASTLOCK;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns single commands into SINGLE / INCRx bursts,
// pipelines address and data phases and reports one response per command.
module ahb_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [2:0]            cmd_size,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    ahb_lite_master_if.master     bus
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT_LAST,
        S_ERR,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [2:0]            r_burst;
    logic [LEN_WIDTH-1:0]  r_beats_left;   // address phases still to issue after the current one
    logic                  r_nonseq;       // current address beat starts a new sequence
    logic                  r_reject;
    logic                  r_err;
    logic                  r_dphase;       // a data phase is in progress on the bus
    logic [DATA_WIDTH-1:0] r_hwdata;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic [ADDR_WIDTH-1:0] w_last_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  w_cross_1k;
    logic                  w_reject;
    logic [2:0]            w_burst;
    htrans_t               w_htrans;
    logic                  w_cmd_accept;
    logic                  w_addr_accept;
    logic                  w_beat_done;
    logic                  w_set_err;
    logic                  w_data_err;

    // Decode an incoming command: legality, 1KB crossing and burst encoding.
    always_comb begin
        w_last_addr = cmd_addr + (ADDR_WIDTH'(cmd_len) << cmd_size);
        w_cross_1k  = (w_last_addr[ADDR_WIDTH-1:10] != cmd_addr[ADDR_WIDTH-1:10]);
        w_reject    = (cmd_size > 3'(MAX_SIZE)) ||
                      ((cmd_addr & ((ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1))) != '0);
        if (w_cross_1k) begin
            w_burst = HBURST_INCR;
        end else begin
            case (32'(cmd_len))
                0:       w_burst = HBURST_SINGLE;
                3:       w_burst = HBURST_INCR4;
                7:       w_burst = HBURST_INCR8;
                15:      w_burst = HBURST_INCR16;
                default: w_burst = HBURST_INCR;
            endcase
        end
    end

    assign w_addr_next = r_addr + (ADDR_WIDTH'(1) << r_size);
    assign w_data_err  = r_dphase && bus.HRESP;

    // Next-state and handshake decode; address beats advance only on HREADY.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_state_next  = r_state;
        w_cmd_accept  = 1'b0;
        w_addr_accept = 1'b0;
        w_beat_done   = 1'b0;
        w_set_err     = 1'b0;
        w_htrans      = HTRANS_IDLE;
        cmd_ready     = 1'b0;
        wr_ready      = 1'b0;
        rsp_valid     = 1'b0;
        rsp_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_cmd_accept = 1'b1;
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (r_reject) begin
                    // Illegal command: respond with an error, never touch the bus.
                    w_set_err    = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_htrans = r_nonseq ? HTRANS_NONSEQ : HTRANS_SEQ;
                    if (w_data_err) begin
                        // HRESP with HREADY low is the first ERROR cycle; with HREADY high
                        // the slave skipped it, so finish immediately.
                        w_set_err    = bus.HREADY;
                        w_state_next = bus.HREADY ? S_DONE : S_ERR;
                    end else if (bus.HREADY) begin
                        w_addr_accept = 1'b1;
                        w_beat_done   = r_dphase;
                        wr_ready      = r_write;
                        if (r_beats_left == '0) begin
                            w_state_next = S_WAIT_LAST;
                        end
                    end
                end
            end
            S_WAIT_LAST: begin
                if (w_data_err) begin
                    w_set_err    = bus.HREADY;
                    w_state_next = bus.HREADY ? S_DONE : S_ERR;
                end else if (bus.HREADY) begin
                    w_beat_done  = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_ERR: begin
                if (bus.HREADY) begin
                    w_set_err    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid    = 1'b1;
                rsp_err      = r_err;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register; reset abandons any outstanding transfer.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
            r_state <= w_state_next;
        end
    end

    // Command latch, address sequencing, write/read data registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_size       <= '0;
            r_burst      <= '0;
            r_beats_left <= '0;
            r_nonseq     <= 1'b0;
            r_reject     <= 1'b0;
            r_err        <= 1'b0;
            r_dphase     <= 1'b0;
            r_hwdata     <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (w_cmd_accept) begin
                r_addr       <= cmd_addr;
                r_write      <= cmd_write;
                r_size       <= cmd_size;
                r_burst      <= w_burst;
                r_beats_left <= cmd_len;
                r_nonseq     <= 1'b1;
                r_reject     <= w_reject;
                r_err        <= 1'b0;
            end
            if (w_addr_accept) begin
                r_addr       <= w_addr_next;
                r_beats_left <= r_beats_left - LEN_WIDTH'(1);
                // A beat landing on a 1KB boundary must restart the sequence.
                r_nonseq     <= (w_addr_next[9:0] == 10'd0);
                if (r_write) begin
                    r_hwdata <= wr_data;
                end
            end
            // Each HREADY edge closes the current data phase and opens the next one, if any.
            if (bus.HREADY) begin
                r_dphase <= w_addr_accept;
            end
            if (w_beat_done && !r_write) begin
                r_rd_data  <= bus.HRDATA;
                r_rd_valid <= 1'b1;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.HADDR     = r_addr;
    assign bus.HWRITE    = r_write;
    assign bus.HSIZE     = r_size;
    assign bus.HBURST    = r_burst;
    assign bus.HTRANS    = w_htrans;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = r_hwdata;
    assign rd_data       = r_rd_data;
    assign rd_valid      = r_rd_valid;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: the bench plays the slave cycle by cycle
// and checks every bus and handshake output against hand-derived values.
module tb_ahb_lite_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [2:0]    cmd_size;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rsp_valid;
    logic          rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    ahb_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ahb_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_size  (cmd_size),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .bus       (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; drive the slave response for the new cycle, then settle.
    task automatic cyc(input logic rdy, input logic resp, input logic [DW-1:0] rdata);
        @(posedge HCLK);
        #1;
        bus.HREADY = rdy;
        bus.HRESP  = resp;
        bus.HRDATA = rdata;
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] addr, input logic wr,
                         input logic [2:0] size, input logic [LW-1:0] len);
        cmd_addr  = addr;
        cmd_write = wr;
        cmd_size  = size;
        cmd_len   = len;
        cmd_valid = 1'b1;
    endtask

    task automatic chk_bus(input string tag, input logic [1:0] trans, input logic [AW-1:0] addr);
        check({tag, ".htrans"}, 64'(bus.HTRANS), 64'(trans));
        check({tag, ".haddr"},  64'(bus.HADDR),  64'(addr));
    endtask

    initial begin
        HRESET     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_size   = '0;
        cmd_len    = '0;
        wr_data    = '0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = '0;
        #12;

        // Reset state
        check("rst.htrans",    64'(bus.HTRANS), 64'(T_IDLE));
        check("rst.cmd_ready", 64'(cmd_ready),  64'd1);
        check("rst.rsp_valid", 64'(rsp_valid),  64'd0);
        check("rst.hprot",     64'(bus.HPROT),  64'h3);
        check("rst.hmastlock", 64'(bus.HMASTLOCK), 64'd0);
        HRESET = 1'b0;
        cyc(1'b1, 1'b0, '0);

        // Single read, zero wait
        issue(32'h100, 1'b0, 3'd2, 4'd0);
        check("t1.cmd_ready_pre", 64'(cmd_ready), 64'd1);
        cyc(1'b1, 1'b0, '0);
        cmd_valid = 1'b0;
        check("t1.cmd_ready", 64'(cmd_ready), 64'd0);
        chk_bus("t1.a0", T_NONSEQ, 32'h100);
        check("t1.hburst", 64'(bus.HBURST), 64'd0);
        check("t1.hsize",  64'(bus.HSIZE),  64'd2);
        check("t1.hwrite", 64'(bus.HWRITE), 64'd0);
        cyc(1'b1, 1'b0, 32'hDEAD_BEEF);
        check("t1.htrans_idle", 64'(bus.HTRANS), 64'(T_IDLE));
        check("t1.rd_valid_early",  64'(rd_valid),  64'd0);
        check("t1.rsp_valid_early", 64'(rsp_valid), 64'd0);
        cyc(1'b1, 1'b0, '0);
        check("t1.rd_valid",  64'(rd_valid),  64'd1);
        check("t1.rd_data",   64'(rd_data),   64'hDEAD_BEEF);
        check("t1.rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1.rsp_err",   64'(rsp_err),   64'd0);
        cyc(1'b1, 1'b0, '0);
        check("t1.cmd_ready_post", 64'(cmd_ready), 64'd1);
        check("t1.rsp_valid_post", 64'(rsp_valid), 64'd0);
        check("t1.rd_valid_post",  64'(rd_valid),  64'd0);

        // INCR4 write with two wait states on the second beat's data phase
        wr_data = 32'hA0A0_0000;
        issue(32'h40, 1'b1, 3'd2, 4'd3);
        cyc(1'b1, 1'b0, '0);
        cmd_valid = 1'b0;
        chk_bus("t2.b0", T_NONSEQ, 32'h40);
        check("t2.hburst",    64'(bus.HBURST), 64'd3);
        check("t2.hwrite",    64'(bus.HWRITE), 64'd1);
        check("t2.wr_ready0", 64'(wr_ready),   64'd1);
        cyc(1'b1, 1'b0, '0);
        wr_data = 32'hA0A0_0001;
        chk_bus("t2.b1", T_SEQ, 32'h44);
        check("t2.hwdata0",   64'(bus.HWDATA), 64'hA0A0_0000);
        check("t2.wr_ready1", 64'(wr_ready),   64'd1);
        cyc(1'b0, 1'b0, '0);
        wr_data = 32'hA0A0_0002;
        chk_bus("t2.wait1", T_SEQ, 32'h48);
        check("t2.wait1.hwdata",   64'(bus.HWDATA), 64'hA0A0_0001);
        check("t2.wait1.wr_ready", 64'(wr_ready),   64'd0);
        cyc(1'b0, 1'b0, '0);
        chk_bus("t2.wait2", T_SEQ, 32'h48);
        check("t2.wait2.hwdata",   64'(bus.HWDATA), 64'hA0A0_0001);
        check("t2.wait2.wr_ready", 64'(wr_ready),   64'd0);
        cyc(1'b1, 1'b0, '0);
        chk_bus("t2.b2", T_SEQ, 32'h48);
        check("t2.b2.hwdata",   64'(bus.HWDATA), 64'hA0A0_0001);
        check("t2.wr_ready2",   64'(wr_ready),   64'd1);
        cyc(1'b1, 1'b0, '0);
        wr_data = 32'hA0A0_0003;
        chk_bus("t2.b3", T_SEQ, 32'h4C);
        check("t2.b3.hwdata", 64'(bus.HWDATA), 64'hA0A0_0002);
        check("t2.wr_ready3", 64'(wr_ready),   64'd1);
        cyc(1'b1, 1'b0, '0);
        check("t2.last.htrans",   64'(bus.HTRANS), 64'(T_IDLE));
        check("t2.last.hwdata",   64'(bus.HWDATA), 64'hA0A0_0003);
        check("t2.last.wr_ready", 64'(wr_ready),   64'd0);
        check("t2.last.rsp_valid", 64'(rsp_valid), 64'd0);
        cyc(1'b1, 1'b0, '0);
        check("t2.rsp_valid", 64'(rsp_valid), 64'd1);
        check("t2.rsp_err",   64'(rsp_err),   64'd0);
        cyc(1'b1, 1'b0, '0);
        check("t2.rsp_valid_post", 64'(rsp_valid), 64'd0);
        check("t2.cmd_ready_post", 64'(cmd_ready), 64'd1);

        // 3-beat read across the 1KB boundary
        issue(32'h3F8, 1'b0, 3'd2, 4'd2);
        cyc(1'b1, 1'b0, '0);
        cmd_valid = 1'b0;
        chk_bus("t3.b0", T_NONSEQ, 32'h3F8);
        check("t3.hburst", 64'(bus.HBURST), 64'd1);
        cyc(1'b1, 1'b0, 32'h1111_0000);
        chk_bus("t3.b1", T_SEQ, 32'h3FC);
        check("t3.rd_valid_early", 64'(rd_valid), 64'd0);
        cyc(1'b1, 1'b0, 32'h1111_0001);
        chk_bus("t3.b2", T_NONSEQ, 32'h400);
        check("t3.rd_valid0", 64'(rd_valid), 64'd1);
        check("t3.rd_data0",  64'(rd_data),  64'h1111_0000);
        cyc(1'b1, 1'b0, 32'h1111_0002);
        check("t3.htrans_idle", 64'(bus.HTRANS), 64'(T_IDLE));
        check("t3.rd_valid1", 64'(rd_valid), 64'd1);
        check("t3.rd_data1",  64'(rd_data),  64'h1111_0001);
        cyc(1'b1, 1'b0, '0);
        check("t3.rd_valid2",  64'(rd_valid),  64'd1);
        check("t3.rd_data2",   64'(rd_data),   64'h1111_0002);
        check("t3.rsp_valid",  64'(rsp_valid), 64'd1);
        check("t3.rsp_err",    64'(rsp_err),   64'd0);
        cyc(1'b1, 1'b0, '0);
        check("t3.rsp_valid_post", 64'(rsp_valid), 64'd0);

        // INCR8 read, ERROR on the third beat
        issue(32'h200, 1'b0, 3'd2, 4'd7);
        cyc(1'b1, 1'b0, '0);
        cmd_valid = 1'b0;
        chk_bus("t4.b0", T_NONSEQ, 32'h200);
        check("t4.hburst", 64'(bus.HBURST), 64'd5);
        cyc(1'b1, 1'b0, 32'h2222_0000);
        chk_bus("t4.b1", T_SEQ, 32'h204);
        cyc(1'b1, 1'b0, 32'h2222_0001);
        chk_bus("t4.b2", T_SEQ, 32'h208);
        check("t4.rd_data0", 64'(rd_data), 64'h2222_0000);
        cyc(1'b0, 1'b1, '0);
        chk_bus("t4.err1", T_SEQ, 32'h20C);
        check("t4.rd_valid1", 64'(rd_valid),  64'd1);
        check("t4.rd_data1",  64'(rd_data),   64'h2222_0001);
        check("t4.err1.rsp_valid", 64'(rsp_valid), 64'd0);
        cyc(1'b1, 1'b1, '0);
        check("t4.err2.htrans",   64'(bus.HTRANS), 64'(T_IDLE));
        check("t4.err2.rd_valid", 64'(rd_valid),   64'd0);
        check("t4.err2.rsp_valid", 64'(rsp_valid), 64'd0);
        cyc(1'b1, 1'b0, '0);
        check("t4.rsp_valid", 64'(rsp_valid), 64'd1);
        check("t4.rsp_err",   64'(rsp_err),   64'd1);
        check("t4.rd_valid",  64'(rd_valid),  64'd0);
        check("t4.htrans",    64'(bus.HTRANS), 64'(T_IDLE));
        cyc(1'b1, 1'b0, '0);
        check("t4.cmd_ready_post", 64'(cmd_ready), 64'd1);
        check("t4.rsp_err_post",   64'(rsp_err),   64'd0);

        // Rejected commands: misaligned address, then oversized beat
        for (int k = 0; k < 2; k++) begin
            if (k == 0) issue(32'h102, 1'b0, 3'd2, 4'd0);
            else        issue(32'h100, 1'b0, 3'd3, 4'd0);
            cyc(1'b1, 1'b0, '0);
            cmd_valid = 1'b0;
            check($sformatf("t5.%0d.htrans0", k),    64'(bus.HTRANS), 64'(T_IDLE));
            check($sformatf("t5.%0d.rsp_early", k),  64'(rsp_valid),  64'd0);
            cyc(1'b1, 1'b0, '0);
            check($sformatf("t5.%0d.htrans1", k),    64'(bus.HTRANS), 64'(T_IDLE));
            check($sformatf("t5.%0d.rsp_valid", k),  64'(rsp_valid),  64'd1);
            check($sformatf("t5.%0d.rsp_err", k),    64'(rsp_err),    64'd1);
            cyc(1'b1, 1'b0, '0);
            check($sformatf("t5.%0d.cmd_ready", k),  64'(cmd_ready),  64'd1);
        end

        // Reset in the middle of an INCR16 write, then a fresh command
        wr_data = 32'hCAFE_0000;
        issue(32'h0, 1'b1, 3'd2, 4'd15);
        cyc(1'b1, 1'b0, '0);
        cmd_valid = 1'b0;
        chk_bus("t6.b0", T_NONSEQ, 32'h0);
        check("t6.hburst", 64'(bus.HBURST), 64'd7);
        repeat (4) cyc(1'b1, 1'b0, '0);
        chk_bus("t6.b4", T_SEQ, 32'h10);
        check("t6.hwdata_pre", 64'(bus.HWDATA), 64'hCAFE_0000);
        #2;
        HRESET = 1'b1;
        #1;
        check("t6.rst.htrans",    64'(bus.HTRANS), 64'(T_IDLE));
        check("t6.rst.haddr",     64'(bus.HADDR),  64'd0);
        check("t6.rst.hburst",    64'(bus.HBURST), 64'd0);
        check("t6.rst.hwrite",    64'(bus.HWRITE), 64'd0);
        check("t6.rst.hsize",     64'(bus.HSIZE),  64'd0);
        check("t6.rst.hwdata",    64'(bus.HWDATA), 64'd0);
        check("t6.rst.cmd_ready", 64'(cmd_ready),  64'd1);
        check("t6.rst.wr_ready",  64'(wr_ready),   64'd0);
        check("t6.rst.rd_data",   64'(rd_data),    64'd0);
        check("t6.rst.rd_valid",  64'(rd_valid),   64'd0);
        check("t6.rst.rsp_valid", 64'(rsp_valid),  64'd0);
        check("t6.rst.rsp_err",   64'(rsp_err),    64'd0);
        #1;
        HRESET = 1'b0;
        cyc(1'b1, 1'b0, '0);
        wr_data = 32'h0000_005A;
        issue(32'h8, 1'b1, 3'd0, 4'd0);
        cyc(1'b1, 1'b0, '0);
        cmd_valid = 1'b0;
        chk_bus("t6.new", T_NONSEQ, 32'h8);
        check("t6.new.hsize",    64'(bus.HSIZE), 64'd0);
        check("t6.new.wr_ready", 64'(wr_ready),  64'd1);
        cyc(1'b1, 1'b0, '0);
        check("t6.new.htrans_idle", 64'(bus.HTRANS), 64'(T_IDLE));
        check("t6.new.hwdata",      64'(bus.HWDATA), 64'h5A);
        cyc(1'b1, 1'b0, '0);
        check("t6.new.rsp_valid", 64'(rsp_valid), 64'd1);
        check("t6.new.rsp_err",   64'(rsp_err),   64'd0);
        cyc(1'b1, 1'b0, '0);
        check("t6.new.cmd_ready", 64'(cmd_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- AHB-Lite initiator (master) that turns simple command requests into single and incrementing-burst AHB transfers.
- Drives the address and control bus and HWDATA. Samples HRDATA, HREADY and HRESP.
- It is the master that talks to the slave-side responder on the existing AHB interface.
- It is the RTL stimulus source for slave bring-up and for loopback checks against the bench's slave driver.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width (32 or 64).
- LEN_WIDTH, 4, width of cmd_len; maximum burst is 2**LEN_WIDTH beats.

Ports:
- HCLK  in  1  bus clock; everything is on posedge.
- HRESET  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_size  in  3  HSIZE encoding for every beat.
- cmd_len  in  LEN_WIDTH  number of beats minus 1.
- wr_data  in  DATA_WIDTH  next write beat data, valid while the command is active.
- wr_ready  out  1  pulse: wr_data consumed this cycle.
- rd_data  out  DATA_WIDTH  read beat data.
- rd_valid  out  1  pulse: rd_data valid.
- rsp_valid  out  1  pulse: command finished.
- rsp_err  out  1  qualifies rsp_valid: 1 = error or rejected command.
- HADDR  out  ADDR_WIDTH  address.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  transfer size.
- HBURST  out  3  burst type.
- HTRANS  out  2  transfer type.
- HPROT  out  4  protection, constant 4'b0011.
- HMASTLOCK  out  1  lock, constant 0.
- HWDATA  out  DATA_WIDTH  write data.
- HRDATA  in  DATA_WIDTH  read data.
- HREADY  in  1  transfer done / wait.
- HRESP  in  1  1 = ERROR.

Behaviour:
- Reset values, applied immediately and asynchronously, including mid-burst:
  - HTRANS=IDLE(00); HADDR, HWRITE, HSIZE, HBURST, HWDATA = 0.
  - wr_ready, rd_valid, rsp_valid, rsp_err, rd_data = 0.
  - cmd_ready=1.
  - An outstanding transfer is abandoned with no response.
- FSM states: IDLE, ADDR, WAIT_LAST, ERR, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge T, latch the command, go to ADDR and drop cmd_ready.
- Command rejection:
  - Rejected if cmd_addr is not aligned to 1<<cmd_size, or if cmd_size > log2(DATA_WIDTH/8).
  - A rejected command goes straight to DONE with rsp_err=1. HTRANS stays IDLE; no bus activity.
- HBURST mapping from cmd_len:
  - 0 -> SINGLE(000); 3 -> INCR4(011); 7 -> INCR8(101); 15 -> INCR16(111).
  - Any other length -> INCR(001).
- ADDR state, address phase per beat:
  - First beat is NONSEQ; later beats are SEQ.
  - HADDR += 1<<cmd_size after each accepted address phase.
  - An address phase is accepted at a posedge with HREADY=1. While HREADY=0, all address and control outputs hold.
- 1KB boundary:
  - If a beat address crosses a 1KB boundary, the whole command is issued as HBURST=INCR.
  - The beat at the boundary is NONSEQ.
- Pipelining: the address phase of beat n+1 overlaps the data phase of beat n. After the last address phase is accepted, go to WAIT_LAST with HTRANS=IDLE.
- Write data:
  - wr_ready pulses in the cycle a write beat's address phase is accepted.
  - wr_data is registered onto HWDATA from the next cycle and held until that data phase completes (HREADY=1).
- Read data:
  - At a data-phase completion with HREADY=1 and HRESP=0, rd_data<=HRDATA and rd_valid pulses for 1 cycle, the cycle after the edge.
- Error handling (two-cycle ERROR):
  - HRESP=1 with HREADY=0 moves the FSM to ERR. HTRANS is driven IDLE in the next cycle, cancelling any pending or queued beats.
  - No wr_ready or rd_valid is issued for the errored or later beats.
  - On HREADY=1, go to DONE with rsp_err=1.
- DONE:
  - rsp_valid pulses for 1 cycle; rsp_err holds only with it.
  - Next cycle: IDLE, cmd_ready=1.
  - Normal completion: rsp_valid fires in the cycle after the last data phase completes. For reads this is the same cycle as the last rd_valid.
- Zero-wait latency:
  - Command accepted at edge T: NONSEQ is on the bus during T..T+1.
  - Single read: rd_valid and rsp_valid both after edge T+2.
  - N-beat burst: rsp_valid after edge T+N+1.
- Simultaneous events:
  - cmd_valid is ignored unless in IDLE.
  - HRESP=1 together with HREADY=1 (protocol violation) is treated as error completion.

Test Plan:
- Single read, cmd_addr=0x100, size=2, len=0, slave zero-wait, HRDATA=0xDEADBEEF -> one NONSEQ @0x100 HBURST=000; rd_data=0xDEADBEEF with rd_valid and rsp_valid both 2 cycles after accept; rsp_err=0.
- INCR4 write @0x40 size=2, slave inserts 2 wait states on beat 2 -> HADDR 0x40,0x44,0x48,0x4C (NONSEQ,SEQ,SEQ,SEQ) HBURST=011; HWDATA and address hold during waits; 4 wr_ready pulses; rsp_valid once.
- Read len=2 (3 beats) @0x3F8 size=2 -> HBURST=001; beat 0x3F8,0x3FC SEQ; 0x400 issued NONSEQ; 3 rd_valid.
- INCR8 read, ERROR response on beat 3 -> HTRANS=IDLE the cycle after the first ERROR cycle; only 2 rd_valid; rsp_valid with rsp_err=1; cmd_ready returns next cycle.
- Misaligned cmd_addr=0x102 size=2 -> no non-IDLE HTRANS; rsp_valid with rsp_err=1 two cycles after accept.
- HRESET asserted mid INCR16 at beat 5 -> all outputs reach reset values without a clock edge; new command after reset completes normally.
